// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Hazard and forwarding controller for the in-order pipeline. It produces
//   per-operand EX forwarding selects and detects load-use hazards. It also
//   tracks one outstanding multicycle (MUL/DIV) operation. While that operation
//   is in flight, ID is stalled on RAW, WAW and structural conflicts until the
//   operation writes back.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
//   mc_stall_cycles performance counter outputs.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   id_valid                   valid instruction in ID
//   id_rs / id_rd              ID sources (packed NUM_SRC x REG_ADDR_W) / dest
//   id_reg_write_en            ID instruction writes rd
//   id_is_mc                   ID instruction is multicycle
//   id_ex_rs / id_ex_rd        EX sources (same packing) / dest
//   id_ex_reg_write_en         EX instruction writes rd
//   id_ex_mem_read             EX instruction is a load
//   id_ex_is_mc                EX instruction is multicycle (issue strobe)
//   ex_mem_rd, ex_mem_reg_write_en_in   MEM-stage writer
//   mem_wb_rd, mem_wb_reg_write_en_in   WB-stage writer
//   forward_sel                per operand 2 bits: 00 none, 01 EX/MEM, 10 MEM/WB
//   stall                      freeze PC and IF/ID, bubble into ID/EX
//   mc_busy                    multicycle op outstanding
//   mc_wb_en, mc_wb_rd         multicycle writeback strobe and destination
//   stall_cycles, mc_stall_cycles  (HAZARD_PERF_CNT_EN only) stall counters
module hazard_forward_unit #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MC_LAT     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write_en,
  input  logic                          id_is_mc,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0]         id_ex_rd,
  input  logic                          id_ex_reg_write_en,
  input  logic                          id_ex_mem_read,
  input  logic                          id_ex_is_mc,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
  input  logic                          ex_mem_reg_write_en_in,
  input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
  input  logic                          mem_wb_reg_write_en_in,
  output logic [2*NUM_SRC-1:0]          forward_sel,
  output logic                          stall,
  output logic                          mc_busy,
  output logic                          mc_wb_en,
  output logic [REG_ADDR_W-1:0]         mc_wb_rd
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   mc_stall_cycles
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] LAT = 4'(MC_LAT);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] mc_rd_q, mc_rd_d;

  logic issue;
  logic lu_hit;
  logic raw_hit;
  logic load_use;
  logic mc_stall;

  // An issue with rd == 0 produces no architectural result, so it is not tracked.
  assign issue = id_ex_is_mc && id_ex_reg_write_en && (id_ex_rd != '0);

  // Multicycle FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
    end
  end

  // Multicycle FSM: next state. An issue seen while BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = LAT;
          mc_rd_d = id_ex_rd;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multicycle FSM: outputs
  always_comb begin
    mc_busy  = (state_q == BUSY);
    mc_wb_en = (state_q == BUSY) && (cnt_q == 4'd1);
    mc_wb_rd = mc_rd_q;
  end

  // Forwarding selects; EX/MEM has priority over MEM/WB.
  always_comb begin
    forward_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (ex_mem_reg_write_en_in && (ex_mem_rd != '0) &&
          (ex_mem_rd == id_ex_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
        forward_sel[2*i +: 2] = 2'b01;
      end else if (mem_wb_reg_write_en_in && (mem_wb_rd != '0) &&
                   (mem_wb_rd == id_ex_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
        forward_sel[2*i +: 2] = 2'b10;
      end
    end
  end

  // Hazard detection
  always_comb begin
    lu_hit  = 1'b0;
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd) lu_hit = 1'b1;
      if (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == mc_rd_q)  raw_hit = 1'b1;
    end
    load_use = id_valid && id_ex_mem_read && id_ex_reg_write_en &&
               (id_ex_rd != '0) && lu_hit;
    mc_stall = mc_busy && id_valid &&
               ((raw_hit && (mc_rd_q != '0)) ||
                (id_reg_write_en && (id_rd == mc_rd_q)) ||
                id_is_mc);
    stall    = load_use || mc_stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] mc_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      mc_stall_cnt_q <= '0;
    end else begin
      if (stall)    stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (mc_stall) mc_stall_cnt_q <= mc_stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign mc_stall_cycles = mc_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: a vector table, hand-written
// multicycle sequences and randomized traffic, all against a cycle-number model.
module tb_hazard_forward_unit;

  localparam int unsigned NS  = 2;
  localparam int unsigned W   = 5;
  localparam int unsigned LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [NS*W-1:0] id_rs;
  logic [W-1:0]    id_rd;
  logic            id_reg_write_en;
  logic            id_is_mc;
  logic [NS*W-1:0] id_ex_rs;
  logic [W-1:0]    id_ex_rd;
  logic            id_ex_reg_write_en;
  logic            id_ex_mem_read;
  logic            id_ex_is_mc;
  logic [W-1:0]    ex_mem_rd;
  logic            ex_mem_reg_write_en_in;
  logic [W-1:0]    mem_wb_rd;
  logic            mem_wb_reg_write_en_in;
  logic [2*NS-1:0] forward_sel;
  logic            stall;
  logic            mc_busy;
  logic            mc_wb_en;
  logic [W-1:0]    mc_wb_rd;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     mc_stall_cycles;
`endif

  hazard_forward_unit #(
    .NUM_SRC(NS),
    .REG_ADDR_W(W),
    .MC_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs(id_rs),
    .id_rd(id_rd),
    .id_reg_write_en(id_reg_write_en),
    .id_is_mc(id_is_mc),
    .id_ex_rs(id_ex_rs),
    .id_ex_rd(id_ex_rd),
    .id_ex_reg_write_en(id_ex_reg_write_en),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_is_mc(id_ex_is_mc),
    .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write_en_in(ex_mem_reg_write_en_in),
    .mem_wb_rd(mem_wb_rd),
    .mem_wb_reg_write_en_in(mem_wb_reg_write_en_in),
    .forward_sel(forward_sel),
    .stall(stall),
    .mc_busy(mc_busy),
    .mc_wb_en(mc_wb_en),
    .mc_wb_rd(mc_wb_rd)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .mc_stall_cycles(mc_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the outstanding operation is described by the cycle
  // number at which it writes back; it is busy in every cycle up to that one.
  int          k = 0;
  bit          mc_active = 1'b0;
  int          mc_end = 0;
  logic [W-1:0] mc_rd_m = '0;
  logic [31:0] sc_m = '0;
  logic [31:0] msc_m = '0;
  logic [2*NS-1:0] fwd_e;
  bit stall_e, mcs_e, busy_e, wb_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
    end
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1;
    id_valid = 1'b0; id_rs = '0; id_rd = '0; id_reg_write_en = 1'b0; id_is_mc = 1'b0;
    id_ex_rs = '0; id_ex_rd = '0; id_ex_reg_write_en = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_is_mc = 1'b0;
    ex_mem_rd = '0; ex_mem_reg_write_en_in = 1'b0;
    mem_wb_rd = '0; mem_wb_reg_write_en_in = 1'b0;
  endtask

  task automatic model_eval();
    logic [W-1:0] r;
    bit lu, raw;
    busy_e = mc_active && (k <= mc_end);
    wb_e   = busy_e && (k == mc_end);
    fwd_e  = '0;
    lu = 0; raw = 0;
    for (int i = 0; i < NS; i++) begin
      r = id_ex_rs[i*W +: W];
      if (ex_mem_reg_write_en_in && ex_mem_rd != 0 && ex_mem_rd == r) fwd_e[2*i +: 2] = 2'b01;
      else if (mem_wb_reg_write_en_in && mem_wb_rd != 0 && mem_wb_rd == r) fwd_e[2*i +: 2] = 2'b10;
      r = id_rs[i*W +: W];
      if (r == id_ex_rd) lu = 1;
      if (r == mc_rd_m && mc_rd_m != 0) raw = 1;
    end
    lu = lu && id_valid && id_ex_mem_read && id_ex_reg_write_en && id_ex_rd != 0;
    mcs_e = busy_e && id_valid && (raw || (id_reg_write_en && id_rd == mc_rd_m) || id_is_mc);
    stall_e = lu || mcs_e;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      mc_active = 0; sc_m = '0; msc_m = '0;
    end else begin
      sc_m  = sc_m + 32'(stall_e);
      msc_m = msc_m + 32'(mcs_e);
      if (!busy_e && id_ex_is_mc && id_ex_reg_write_en && id_ex_rd != 0) begin
        mc_active = 1; mc_end = k + int'(LAT); mc_rd_m = id_ex_rd;
      end
    end
    k++;
  endtask

  // One clock cycle: model comparison plus optional hand-written expectations
  // (-1 means "not checked by hand in this cycle").
  task automatic tick(input string tag, input int hf, input int hs, input int hb,
                      input int hw, input int hrd);
    @(negedge clk);
    model_eval();
    chk("fwd", 32'(forward_sel), 32'(fwd_e));
    chk("stall", 32'(stall), 32'(stall_e));
    chk("busy", 32'(mc_busy), 32'(busy_e));
    chk("wb_en", 32'(mc_wb_en), 32'(wb_e));
    if (wb_e) chk("wb_rd", 32'(mc_wb_rd), 32'(mc_rd_m));
    if (hf >= 0)  chk({tag, "_fwd"},   32'(forward_sel), 32'(hf));
    if (hs >= 0)  chk({tag, "_stall"}, 32'(stall),       32'(hs));
    if (hb >= 0)  chk({tag, "_busy"},  32'(mc_busy),     32'(hb));
    if (hw >= 0)  chk({tag, "_wb_en"}, 32'(mc_wb_en),    32'(hw));
    if (hrd >= 0) chk({tag, "_wb_rd"}, 32'(mc_wb_rd),    32'(hrd));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, sc_m);
    chk("mc_stall_cycles", mc_stall_cycles, msc_m);
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // MUL to x9 issued at T while ID reads x9.
  task automatic mc_raw_seq();
    idle_inputs();
    id_valid = 1'b1; id_rs = {5'd0, 5'd9};
    id_ex_is_mc = 1'b1; id_ex_reg_write_en = 1'b1; id_ex_rd = 5'd9;
    tick("raw_T", -1, 0, 0, 0, -1);
    id_ex_is_mc = 1'b0; id_ex_reg_write_en = 1'b0; id_ex_rd = '0;
    for (int j = 1; j <= int'(LAT); j++)
      tick($sformatf("raw_T%0d", j), -1, 1, 1, (j == int'(LAT)) ? 1 : 0,
           (j == int'(LAT)) ? 9 : -1);
    tick("raw_T5", -1, 0, 0, 0, -1);
    idle_inputs();
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] exm_rd;  logic exm_we;
    logic [W-1:0] mwb_rd;  logic mwb_we;
    logic [NS*W-1:0] ex_rs;
    logic [W-1:0] ex_rd;   logic ex_we; logic ex_ld;
    logic         idv;     logic [NS*W-1:0] rs;
    logic [2*NS-1:0] fwd;  logic stl;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{"both_x5",   5'd5, 1, 5'd5, 1, {5'd5, 5'd5}, 5'd0, 0, 0, 0, {5'd0, 5'd0}, 4'b0101, 0};
    vt[1]  = '{"both_x0",   5'd0, 1, 5'd0, 1, {5'd0, 5'd0}, 5'd0, 0, 0, 0, {5'd0, 5'd0}, 4'b0000, 0};
    vt[2]  = '{"split",     5'd3, 1, 5'd4, 1, {5'd3, 5'd4}, 5'd0, 0, 0, 0, {5'd0, 5'd0}, 4'b0110, 0};
    vt[3]  = '{"wb_only",   5'd0, 0, 5'd6, 1, {5'd6, 5'd6}, 5'd0, 0, 0, 0, {5'd0, 5'd0}, 4'b1010, 0};
    vt[4]  = '{"mem_off",   5'd8, 0, 5'd8, 1, {5'd1, 5'd8}, 5'd0, 0, 0, 0, {5'd0, 5'd0}, 4'b0010, 0};
    vt[5]  = '{"mem_op1",   5'd8, 1, 5'd1, 0, {5'd8, 5'd1}, 5'd0, 0, 0, 0, {5'd0, 5'd0}, 4'b0100, 0};
    vt[6]  = '{"lu_op1",    5'd0, 0, 5'd0, 0, {5'd0, 5'd0}, 5'd7, 1, 1, 1, {5'd7, 5'd0}, 4'b0000, 1};
    vt[7]  = '{"lu_novalid",5'd0, 0, 5'd0, 0, {5'd0, 5'd0}, 5'd7, 1, 1, 0, {5'd7, 5'd0}, 4'b0000, 0};
    vt[8]  = '{"lu_rd0",    5'd0, 0, 5'd0, 0, {5'd0, 5'd0}, 5'd0, 1, 1, 1, {5'd0, 5'd0}, 4'b0000, 0};
    vt[9]  = '{"lu_nowe",   5'd0, 0, 5'd0, 0, {5'd0, 5'd0}, 5'd7, 0, 1, 1, {5'd7, 5'd0}, 4'b0000, 0};
    vt[10] = '{"lu_noload", 5'd0, 0, 5'd0, 0, {5'd0, 5'd0}, 5'd7, 1, 0, 1, {5'd7, 5'd0}, 4'b0000, 0};
    vt[11] = '{"lu_op0",    5'd0, 0, 5'd0, 0, {5'd0, 5'd0}, 5'd7, 1, 1, 1, {5'd0, 5'd7}, 4'b0000, 1};

    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("reset", 0, 0, 0, 0, 0);

    // Combinational table (unit idle throughout)
    foreach (vt[n]) begin
      idle_inputs();
      ex_mem_rd = vt[n].exm_rd; ex_mem_reg_write_en_in = vt[n].exm_we;
      mem_wb_rd = vt[n].mwb_rd; mem_wb_reg_write_en_in = vt[n].mwb_we;
      id_ex_rs = vt[n].ex_rs; id_ex_rd = vt[n].ex_rd;
      id_ex_reg_write_en = vt[n].ex_we; id_ex_mem_read = vt[n].ex_ld;
      id_valid = vt[n].idv; id_rs = vt[n].rs;
      tick(vt[n].name, int'(vt[n].fwd), int'(vt[n].stl), 0, 0, -1);
    end
    idle_inputs();
    tick("lu_release", 0, 0, 0, 0, -1);

    mc_raw_seq();

    // WAW / structural / independent while BUSY; a stray issue is ignored.
    id_ex_is_mc = 1'b1; id_ex_reg_write_en = 1'b1; id_ex_rd = 5'd9;
    tick("busy_T", -1, 0, 0, 0, -1);
    idle_inputs();
    id_valid = 1'b1; id_reg_write_en = 1'b1; id_rd = 5'd9;
    tick("waw", -1, 1, 1, 0, -1);
    idle_inputs();
    id_valid = 1'b1; id_is_mc = 1'b1;
    id_ex_is_mc = 1'b1; id_ex_reg_write_en = 1'b1; id_ex_rd = 5'd12;
    tick("struct", -1, 1, 1, 0, -1);
    idle_inputs();
    id_valid = 1'b1; id_rs = {5'd3, 5'd3}; id_rd = 5'd3; id_reg_write_en = 1'b1;
    tick("indep", -1, 0, 1, 0, -1);
    tick("busy_wb", -1, 0, 1, 1, 9);
    tick("busy_done", -1, 0, 0, 0, -1);
    idle_inputs();

    // Reset during an operation
    id_ex_is_mc = 1'b1; id_ex_reg_write_en = 1'b1; id_ex_rd = 5'd9;
    tick("rst_T", -1, 0, 0, 0, -1);
    idle_inputs();
    id_valid = 1'b1; id_rs = {5'd0, 5'd9};
    tick("rst_T1", -1, 1, 1, 0, -1);
    rst_n = 1'b0;
    tick("rst_T2", -1, -1, 1, 0, -1);
    rst_n = 1'b1;
    for (int j = 3; j <= 6; j++)
      tick($sformatf("rst_T%0d", j), -1, 0, 0, 0, -1);
    idle_inputs();

`ifdef HAZARD_PERF_CNT_EN
    rst_n = 1'b0;
    tick("perf_rst", -1, -1, -1, -1, -1);
    mc_raw_seq();
    id_valid = 1'b1; id_rs = {5'd7, 5'd0};
    id_ex_rd = 5'd7; id_ex_reg_write_en = 1'b1; id_ex_mem_read = 1'b1;
    tick("perf_lu", -1, 1, 0, 0, -1);
    idle_inputs();
    tick("perf_idle", -1, 0, 0, 0, -1);
    chk("perf_stall_cycles", stall_cycles, 32'd5);
    chk("perf_mc_stall_cycles", mc_stall_cycles, 32'd4);
`endif

    // Randomized traffic with small register numbers to provoke matches
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(99, 0) != 0);
      id_valid = 1'($urandom_range(1, 0));
      for (int i = 0; i < NS; i++) begin
        id_rs[i*W +: W]    = W'($urandom_range(7, 0));
        id_ex_rs[i*W +: W] = W'($urandom_range(7, 0));
      end
      id_rd = W'($urandom_range(7, 0));
      id_reg_write_en = 1'($urandom_range(1, 0));
      id_is_mc = ($urandom_range(7, 0) == 0);
      id_ex_rd = W'($urandom_range(7, 0));
      id_ex_reg_write_en = 1'($urandom_range(1, 0));
      id_ex_mem_read = ($urandom_range(3, 0) == 0);
      id_ex_is_mc = ($urandom_range(5, 0) == 0);
      ex_mem_rd = W'($urandom_range(7, 0));
      ex_mem_reg_write_en_in = 1'($urandom_range(1, 0));
      mem_wb_rd = W'($urandom_range(7, 0));
      mem_wb_reg_write_en_in = 1'($urandom_range(1, 0));
      tick("rand", -1, -1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
